trigger_capture_buffer: RTL and testbench
=========================================

TRIGGER_CAPTURE_BUFFER -- requirements
Module: trigger_capture_buffer

Interface
REQ-001 SHALL have parameter SAMPLE_WIDTH, default 16, meaning bits per ADC sample.
REQ-002 SHALL have parameter LANES, default 8, meaning samples per input beat (power of 2).
REQ-003 SHALL have parameter DEPTH_WORDS, default 128, meaning RAM depth in input beats (power of 2).
REQ-004 SHALL have parameter PRETRIG_WORDS, default 16, meaning beats kept from before the trigger (< DEPTH_WORDS).
REQ-005 SHALL have parameter C_M00_AXIS_TDATA_WIDTH, default 32, meaning output width (>= SAMPLE_WIDTH).
REQ-006 SHALL have ports: s00_axis_aclk in 1, the single clock; s00_axis_areset in 1, reset, asynchronous and active-high.
REQ-007 SHALL have ports: s00_axis_tvalid in 1; s00_axis_tdata in SAMPLE_WIDTH*LANES, lane 0 in the LSBs and first in time; s00_axis_tlast in 1, ignored; s00_axis_tready out 1.
REQ-008 SHALL have ports: m00_axis_tready in 1; m00_axis_tvalid out 1; m00_axis_tlast out 1; m00_axis_tdata out C_M00_AXIS_TDATA_WIDTH; m00_axis_tstrb out C_M00_AXIS_TDATA_WIDTH/8.
REQ-009 SHALL have ports: laser_trigger in 1, level, synchronous to the clock; busy out 1, high outside ARMED.

Function
REQ-010 SHALL implement FSM PREFILL -> ARMED -> CAPTURE -> DUMP -> PREFILL.
REQ-011 PREFILL/ARMED/CAPTURE SHALL hold s00_axis_tready=1; DUMP SHALL hold it 0.
REQ-012 Every accepted input beat SHALL write RAM[wr_ptr], and wr_ptr SHALL increment modulo DEPTH_WORDS.
REQ-013 PREFILL SHALL move to ARMED after PRETRIG_WORDS accepted beats.
REQ-014 Trigger SHALL be a rising edge of laser_trigger (registered previous value); edges outside ARMED SHALL be ignored.
REQ-015 A rising edge in ARMED SHALL latch start_ptr = (wr_ptr - PRETRIG_WORDS) mod DEPTH_WORDS and enter CAPTURE; a beat accepted in that same cycle SHALL count as the first post-trigger beat.
REQ-016 CAPTURE SHALL accept DEPTH_WORDS - PRETRIG_WORDS beats, then enter DUMP.
REQ-017 DUMP SHALL emit DEPTH_WORDS*LANES samples, reading from start_ptr with wrap, lane 0 first.
REQ-018 Each sample SHALL be sign-extended to C_M00_AXIS_TDATA_WIDTH.
REQ-019 m00_axis_tstrb SHALL be all ones.
REQ-020 m00_axis_tvalid/tdata SHALL be held stable until m00_axis_tready is high; no sample SHALL be dropped or duplicated under any tready pattern.
REQ-021 The RAM read latency of 1 cycle SHALL be absorbed by prefetch, so back-to-back transfers occur when tready is held high.
REQ-022 m00_axis_tlast SHALL be high only on the final sample.
REQ-023 After the final handshake the FSM SHALL return to PREFILL with the PREFILL counter cleared.
REQ-024 frame_count (16 bit) SHALL increment after each completed dump, wrapping at 65535.

Reset
REQ-025 Asserting s00_axis_areset at any time, including mid-DUMP, SHALL immediately force: state PREFILL; pointers and counters 0; m00_axis_tvalid=0, m00_axis_tlast=0, m00_axis_tdata=0; busy=1; s00_axis_tready=0 while reset is asserted.
REQ-026 RAM contents SHALL NOT be reset.

Configuration
REQ-027 With macro TRIGGER_CAPTURE_HEADER_EN defined, each dump SHALL begin with one extra beat {frame_count[15:0], PRETRIG_WORDS[15:0]} (low bits of C_M00_AXIS_TDATA_WIDTH), followed by the samples.
REQ-028 Without TRIGGER_CAPTURE_HEADER_EN, no header beat SHALL be emitted.
REQ-029 tlast placement SHALL be unchanged in both cases.

Structure
REQ-030 Package trigger_capture_pkg SHALL hold the FSM state enum (PREFILL, ARMED, CAPTURE, DUMP) and the header field widths.
REQ-031 Storage SHALL be a sub-module capture_ram_sdp: single-clock simple dual-port, 1-cycle registered read.

Verification (SAMPLE_WIDTH=16, LANES=4, DEPTH_WORDS=16, PRETRIG_WORDS=4, tdata counting beats)
REQ-032 Stream beats 0..29 continuously, rising edge at beat 10 -> 64 samples emitted from beats 6..21 in order; tlast on sample 63; busy returns low after 4 more beats.
REQ-033 Trigger pulse at beat 2, during PREFILL -> ignored; no output; ARMED is entered after beat 3.
REQ-034 Random 50% m00_axis_tready -> identical 64-sample sequence; tvalid/tdata stable while stalled.
REQ-035 Samples 0x8000 and 0x7FFF -> output 0xFFFF8000 and 0x00007FFF.
REQ-036 Reset asserted after 20 samples dumped -> tvalid=0 immediately; the next trigger yields a complete, correct frame.
REQ-037 With TRIGGER_CAPTURE_HEADER_EN, two frames -> headers 0x00000004 and 0x00010004, each followed by 64 samples, tlast on the last sample only.

Source files
------------

// File: rtl/trigger_capture_pkg.sv
// -----------------------------------------------------------------------------
// trigger_capture_pkg
// Shared types and constants for the trigger capture buffer.
//   capture_state_t : capture FSM states (PREFILL, ARMED, CAPTURE, DUMP)
//   HDR_FRAME_W     : width of the frame counter field in the optional header
//   HDR_PRETRIG_W   : width of the pre-trigger depth field in the optional header
// -----------------------------------------------------------------------------
package trigger_capture_pkg;

    typedef enum logic [1:0] {
        PREFILL = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DUMP    = 2'd3
    } capture_state_t;

    localparam int HDR_FRAME_W   = 16;
    localparam int HDR_PRETRIG_W = 16;

endpackage : trigger_capture_pkg

// File: rtl/capture_ram_sdp.sv
// -----------------------------------------------------------------------------
// capture_ram_sdp
// Single-clock simple dual-port RAM with one registered read port.
// Read data appears one cycle after rd_en and is held until the next rd_en,
// so the output register doubles as a one-word holding buffer.
// Contents are never reset.
// Ports:
//   clk     : clock
//   wr_en   : write strobe; wr_addr / wr_data : write address / data
//   rd_en   : read strobe;  rd_addr           : read address
//   rd_data : registered read data
// -----------------------------------------------------------------------------
module capture_ram_sdp #(
    parameter int DATA_W = 128,
    parameter int DEPTH  = 128,
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [DATA_W-1:0] rd_data_r;

    // Write port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Registered read port; holds its value while rd_en is low.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data_r <= mem_r[rd_addr];
        end
    end

    assign rd_data = rd_data_r;

endmodule : capture_ram_sdp

// File: rtl/trigger_capture_buffer.sv
// -----------------------------------------------------------------------------
// trigger_capture_buffer
// Continuously records a multi-lane ADC stream into a circular RAM. After
// PRETRIG_WORDS beats of history are present the block arms; a rising edge of
// laser_trigger then captures the remaining DEPTH_WORDS - PRETRIG_WORDS beats
// and the whole window (pre- and post-trigger) is streamed out one
// sign-extended sample per beat, lane 0 first, before the block re-arms.
//
// Optional feature: define TRIGGER_CAPTURE_HEADER_EN to prefix every dump with
// one header beat {frame_count[15:0], PRETRIG_WORDS[15:0]}.
//
// Assumes PRETRIG_WORDS >= 1 and DEPTH_WORDS >= 2.
//
// Ports:
//   s00_axis_aclk / s00_axis_areset : clock, async active-high reset
//   s00_axis_*  : sample input stream (tlast ignored); tready low during dump
//   m00_axis_*  : sample output stream, tstrb constant all ones
//   laser_trigger : trigger level, synchronous to the clock
//   busy          : high whenever the block is not armed
// -----------------------------------------------------------------------------
module trigger_capture_buffer
    import trigger_capture_pkg::*;
#(
    parameter int SAMPLE_WIDTH           = 16,
    parameter int LANES                  = 8,
    parameter int DEPTH_WORDS            = 128,
    parameter int PRETRIG_WORDS          = 16,
    parameter int C_M00_AXIS_TDATA_WIDTH = 32
) (
    input  logic                                s00_axis_aclk,
    input  logic                                s00_axis_areset,
    input  logic                                s00_axis_tvalid,
    input  logic [SAMPLE_WIDTH*LANES-1:0]       s00_axis_tdata,
    input  logic                                s00_axis_tlast,
    output logic                                s00_axis_tready,
    input  logic                                m00_axis_tready,
    output logic                                m00_axis_tvalid,
    output logic                                m00_axis_tlast,
    output logic [C_M00_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
    output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tstrb,
    input  logic                                laser_trigger,
    output logic                                busy
);

    localparam int OUT_W  = C_M00_AXIS_TDATA_WIDTH;
    localparam int WORD_W = SAMPLE_WIDTH * LANES;
    localparam int ADDR_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W  = ADDR_W + 1;
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int NSAMP  = DEPTH_WORDS * LANES;
    localparam int SCNT_W = $clog2(NSAMP) + 1;

    localparam logic [CNT_W-1:0]  PRE_CNT     = CNT_W'(PRETRIG_WORDS);
    localparam logic [CNT_W-1:0]  POST_CNT    = CNT_W'(DEPTH_WORDS - PRETRIG_WORDS);
    localparam logic [CNT_W-1:0]  DEPTH_CNT   = CNT_W'(DEPTH_WORDS);
    localparam logic [ADDR_W-1:0] PRE_PTR     = ADDR_W'(PRETRIG_WORDS);
    localparam logic [LANE_W-1:0] LAST_LANE   = LANE_W'(LANES - 1);
    localparam logic [SCNT_W-1:0] LAST_SAMPLE = SCNT_W'(NSAMP - 1);

    // Sign-extend one ADC sample to the output width.
    function automatic logic [OUT_W-1:0] sign_extend(input logic [SAMPLE_WIDTH-1:0] sample);
        return OUT_W'($signed(sample));
    endfunction

`ifdef TRIGGER_CAPTURE_HEADER_EN
    // Header beat: frame number above the pre-trigger depth, truncated/zero-filled to OUT_W.
    function automatic logic [OUT_W-1:0] header_word(input logic [HDR_FRAME_W-1:0] frame);
        logic [HDR_FRAME_W+HDR_PRETRIG_W-1:0] raw;
        raw = {frame, HDR_PRETRIG_W'(PRETRIG_WORDS)};
        return OUT_W'(raw);
    endfunction
`endif

    // Control state
    capture_state_t      state_r;
    logic                trig_prev_r;
    logic [ADDR_W-1:0]   wr_ptr_r;
    logic [CNT_W-1:0]    prefill_cnt_r;
    logic [CNT_W-1:0]    post_cnt_r;
    logic [15:0]         frame_cnt_r;
    logic                tready_r;
    logic                busy_r;

    // Dump datapath state
    logic [ADDR_W-1:0]   rd_ptr_r;      // latched start_ptr, then next word to fetch
    logic [CNT_W-1:0]    words_left_r;  // words not yet fetched from RAM
    logic                word_valid_r;  // RAM read register holds an unconsumed word
    logic [LANE_W-1:0]   lane_r;
    logic [SCNT_W-1:0]   samp_cnt_r;
    logic                tvalid_r;
    logic                tlast_r;
    logic [OUT_W-1:0]    tdata_r;
`ifdef TRIGGER_CAPTURE_HEADER_EN
    logic                hdr_pending_r;
`endif

    // Combinational helpers
    logic                accept_s;
    logic                rise_s;
    logic                dumping_s;
    logic                out_free_s;
    logic                last_lane_s;
    logic                hdr_pend_s;
    logic                load_hdr_s;
    logic                load_smp_s;
    logic                fetch_s;
    logic                final_hs_s;
    logic [WORD_W-1:0]   rd_data_s;
    logic [SAMPLE_WIDTH-1:0] sample_s;
    logic                unused_s;

    assign unused_s = s00_axis_tlast;

    assign accept_s    = s00_axis_tvalid & tready_r;
    assign rise_s      = laser_trigger & ~trig_prev_r;
    assign dumping_s   = (state_r == DUMP);
    assign out_free_s  = ~tvalid_r | m00_axis_tready;
    assign last_lane_s = (lane_r == LAST_LANE);
`ifdef TRIGGER_CAPTURE_HEADER_EN
    assign hdr_pend_s  = hdr_pending_r;
`else
    assign hdr_pend_s  = 1'b0;
`endif
    assign load_hdr_s  = dumping_s & out_free_s & hdr_pend_s;
    assign load_smp_s  = dumping_s & out_free_s & ~hdr_pend_s & word_valid_r;
    // Fetch the first word on entry and the next word as the last lane of the
    // current one is handed to the output register, hiding the read latency.
    assign fetch_s     = dumping_s & (words_left_r != CNT_W'(0)) &
                         (~word_valid_r | (load_smp_s & last_lane_s));
    assign final_hs_s  = dumping_s & tvalid_r & m00_axis_tready & tlast_r;

    // Select the current lane of the fetched word.
    always_comb begin
        sample_s = rd_data_s[int'(lane_r)*SAMPLE_WIDTH +: SAMPLE_WIDTH];
    end

    capture_ram_sdp #(
        .DATA_W (WORD_W),
        .DEPTH  (DEPTH_WORDS),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (s00_axis_aclk),
        .wr_en   (accept_s),
        .wr_addr (wr_ptr_r),
        .wr_data (s00_axis_tdata),
        .rd_en   (fetch_s),
        .rd_addr (rd_ptr_r),
        .rd_data (rd_data_s)
    );

    // Capture FSM: write pointer, trigger detection, phase counters, input ready and busy.
    always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
        if (s00_axis_areset) begin
            state_r       <= PREFILL;
            trig_prev_r   <= 1'b0;
            wr_ptr_r      <= ADDR_W'(0);
            prefill_cnt_r <= CNT_W'(0);
            post_cnt_r    <= CNT_W'(0);
            frame_cnt_r   <= 16'd0;
            tready_r      <= 1'b0;
            busy_r        <= 1'b1;
        end else begin
            trig_prev_r <= laser_trigger;
            if (accept_s) begin
                wr_ptr_r <= wr_ptr_r + ADDR_W'(1);
            end
            case (state_r)
                PREFILL: begin
                    tready_r <= 1'b1;
                    busy_r   <= 1'b1;
                    if (accept_s) begin
                        if (prefill_cnt_r == PRE_CNT - CNT_W'(1)) begin
                            state_r       <= ARMED;
                            busy_r        <= 1'b0;
                            prefill_cnt_r <= CNT_W'(0);
                        end else begin
                            prefill_cnt_r <= prefill_cnt_r + CNT_W'(1);
                        end
                    end
                end
                ARMED: begin
                    tready_r <= 1'b1;
                    busy_r   <= 1'b0;
                    if (rise_s) begin
                        busy_r <= 1'b1;
                        // A beat accepted alongside the edge is the first post-trigger beat.
                        if (accept_s && (POST_CNT == CNT_W'(1))) begin
                            state_r  <= DUMP;
                            tready_r <= 1'b0;
                        end else begin
                            state_r    <= CAPTURE;
                            post_cnt_r <= accept_s ? CNT_W'(1) : CNT_W'(0);
                        end
                    end
                end
                CAPTURE: begin
                    tready_r <= 1'b1;
                    busy_r   <= 1'b1;
                    if (accept_s) begin
                        if (post_cnt_r == POST_CNT - CNT_W'(1)) begin
                            state_r  <= DUMP;
                            tready_r <= 1'b0;
                        end else begin
                            post_cnt_r <= post_cnt_r + CNT_W'(1);
                        end
                    end
                end
                DUMP: begin
                    busy_r <= 1'b1;
                    if (final_hs_s) begin
                        state_r       <= PREFILL;
                        prefill_cnt_r <= CNT_W'(0);
                        tready_r      <= 1'b1;
                        frame_cnt_r   <= frame_cnt_r + 16'd1;
                    end else begin
                        tready_r <= 1'b0;
                    end
                end
                default: begin
                    state_r  <= PREFILL;
                    tready_r <= 1'b0;
                    busy_r   <= 1'b1;
                end
            endcase
        end
    end

    // Dump datapath: RAM fetch sequencing and the registered output stage.
    always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
        if (s00_axis_areset) begin
            rd_ptr_r     <= ADDR_W'(0);
            words_left_r <= CNT_W'(0);
            word_valid_r <= 1'b0;
            lane_r       <= LANE_W'(0);
            samp_cnt_r   <= SCNT_W'(0);
            tvalid_r     <= 1'b0;
            tlast_r      <= 1'b0;
            tdata_r      <= OUT_W'(0);
`ifdef TRIGGER_CAPTURE_HEADER_EN
            hdr_pending_r <= 1'b0;
`endif
        end else if (!dumping_s) begin
            // Keep the dump sequencer preset so DUMP can start on its first cycle.
            if ((state_r == ARMED) && rise_s) begin
                rd_ptr_r <= wr_ptr_r - PRE_PTR;
            end
            words_left_r <= DEPTH_CNT;
            word_valid_r <= 1'b0;
            lane_r       <= LANE_W'(0);
            samp_cnt_r   <= SCNT_W'(0);
            tvalid_r     <= 1'b0;
            tlast_r      <= 1'b0;
`ifdef TRIGGER_CAPTURE_HEADER_EN
            hdr_pending_r <= 1'b1;
`endif
        end else begin
            if (fetch_s) begin
                rd_ptr_r     <= rd_ptr_r + ADDR_W'(1);
                words_left_r <= words_left_r - CNT_W'(1);
                word_valid_r <= 1'b1;
            end else if (load_smp_s && last_lane_s) begin
                word_valid_r <= 1'b0;
            end

            if (load_hdr_s) begin
`ifdef TRIGGER_CAPTURE_HEADER_EN
                tdata_r       <= header_word(frame_cnt_r);
                hdr_pending_r <= 1'b0;
`endif
                tvalid_r <= 1'b1;
                tlast_r  <= 1'b0;
            end else if (load_smp_s) begin
                tdata_r    <= sign_extend(sample_s);
                tvalid_r   <= 1'b1;
                tlast_r    <= (samp_cnt_r == LAST_SAMPLE);
                samp_cnt_r <= samp_cnt_r + SCNT_W'(1);
                lane_r     <= last_lane_s ? LANE_W'(0) : lane_r + LANE_W'(1);
            end else if (m00_axis_tready) begin
                tvalid_r <= 1'b0;
                tlast_r  <= 1'b0;
            end
        end
    end

    assign s00_axis_tready = tready_r;
    assign busy            = busy_r;
    assign m00_axis_tvalid = tvalid_r;
    assign m00_axis_tlast  = tlast_r;
    assign m00_axis_tdata  = tdata_r;
    assign m00_axis_tstrb  = {(C_M00_AXIS_TDATA_WIDTH/8){1'b1}};

endmodule : trigger_capture_buffer

// File: tb/tb_trigger_capture_buffer.sv
// -----------------------------------------------------------------------------
// tb_trigger_capture_buffer
// Randomized self-checking bench. The reference model tracks the input stream
// as a numbered list of beats and derives each frame from the trigger beat
// index: samples come from beats t-PRE .. t+POST-1, lane 0 first.
// -----------------------------------------------------------------------------
module tb_trigger_capture_buffer;

    localparam int SW   = 16;
    localparam int LN   = 4;
    localparam int DW   = 16;
    localparam int PW   = 4;
    localparam int OW   = 32;
    localparam int POST = DW - PW;
    localparam int NS   = DW * LN;
`ifdef TRIGGER_CAPTURE_HEADER_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif

    logic              clk;
    logic              rst;
    logic              s_tvalid;
    logic [SW*LN-1:0]  s_tdata;
    logic              s_tlast;
    logic              s_tready;
    logic              m_ready;
    logic              m_tvalid;
    logic              m_tlast;
    logic [OW-1:0]     m_tdata;
    logic [OW/8-1:0]   m_tstrb;
    logic              laser;
    logic              busy;

    trigger_capture_buffer #(
        .SAMPLE_WIDTH           (SW),
        .LANES                  (LN),
        .DEPTH_WORDS            (DW),
        .PRETRIG_WORDS          (PW),
        .C_M00_AXIS_TDATA_WIDTH (OW)
    ) dut (
        .s00_axis_aclk   (clk),
        .s00_axis_areset (rst),
        .s00_axis_tvalid (s_tvalid),
        .s00_axis_tdata  (s_tdata),
        .s00_axis_tlast  (s_tlast),
        .s00_axis_tready (s_tready),
        .m00_axis_tready (m_ready),
        .m00_axis_tvalid (m_tvalid),
        .m00_axis_tlast  (m_tlast),
        .m00_axis_tdata  (m_tdata),
        .m00_axis_tstrb  (m_tstrb),
        .laser_trigger   (laser),
        .busy            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Compare one observed value against its expected value.
    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Stimulus data and model state
    logic [63:0] beat_data [0:4095];
    int          n;            // index of the next beat to be accepted
    int          base;         // first beat index of the current frame
    int          m_t;          // trigger beat index of the frame being captured
    int          frame_no;
    bit          m_in_frame;
    bit          m_dumping;
    bit          trig_prev;
    bit          stall_prev;
    logic [OW-1:0] prev_data;
    logic [32:0] exp_q [$];
    logic [31:0] seen_q [$];
    int          trig_a, trig_b, trig_c;
    bit          valid_rand, ready_rand;

    task automatic model_reset();
        base       = n;
        m_in_frame = 1'b0;
        m_dumping  = 1'b0;
        frame_no   = 0;
        trig_prev  = 1'b0;
        stall_prev = 1'b0;
        exp_q.delete();
    endtask

    // Queue the full expected output of a frame triggered at beat t.
    task automatic push_frame(input int t);
        logic [63:0] beat;
        logic [15:0] s;
        logic [15:0] fno;
        if (HDR != 0) begin
            fno = frame_no[15:0];
            exp_q.push_back({1'b0, fno, 16'd4});
        end
        for (int k = 0; k < NS; k++) begin
            beat = beat_data[t - PW + k / LN];
            s    = beat[(k % LN) * SW +: SW];
            exp_q.push_back({(k == NS - 1), {16{s[15]}}, s});
        end
    endtask

    // One clock cycle: drive inputs, check status against the model, score outputs.
    task automatic step();
        bit trig_now;
        bit armed;
        logic [32:0] item;
        @(negedge clk);
        if (stall_prev) begin
            check_eq("hold_valid", m_tvalid, 1'b1);
            check_eq("hold_data", m_tdata, prev_data);
        end
        s_tvalid = valid_rand ? ($urandom_range(0, 4) != 0) : 1'b1;
        s_tdata  = beat_data[n];
        trig_now = (n == trig_a) || (n == trig_b) || (n == trig_c);
        laser    = trig_now;
        m_ready  = ready_rand ? ($urandom_range(0, 1) == 1) : 1'b1;

        armed = !m_in_frame && (n >= base + PW);
        check_eq("s_tready", s_tready, !m_dumping);
        check_eq("busy", busy, !armed);

        if (trig_now && !trig_prev && armed) begin
            m_in_frame = 1'b1;
            m_t        = n;
            push_frame(n);
        end
        trig_prev = trig_now;

        if (s_tvalid && s_tready) begin
            n++;
            if (m_in_frame && !m_dumping && (n == m_t + POST)) begin
                m_dumping = 1'b1;
            end
        end

        stall_prev = m_tvalid && !m_ready;
        prev_data  = m_tdata;
        if (m_tvalid && m_ready) begin
            check_eq("out_avail", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
                item = exp_q.pop_front();
                check_eq("out_data", m_tdata, item[31:0]);
                check_eq("out_last", m_tlast, item[32]);
                seen_q.push_back(m_tdata);
                if (item[32]) begin
                    m_in_frame = 1'b0;
                    m_dumping  = 1'b0;
                    base       = n;
                    frame_no++;
                end
            end
        end
    endtask

    task automatic idle_inputs();
        s_tvalid = 1'b0;
        laser    = 1'b0;
        m_ready  = 1'b0;
    endtask

    task automatic end_of_frame_checks(input string tag);
        check_eq({tag, "_frame_done"}, m_in_frame, 1'b0);
        check_eq({tag, "_exp_empty"}, exp_q.size(), 0);
        check_eq({tag, "_frame_len"}, seen_q.size(), NS + HDR);
    endtask

    initial begin
        int cyc;
        rst     = 1'b1;
        s_tlast = 1'b0;
        s_tdata = '0;
        idle_inputs();
        for (int i = 0; i < 4096; i++) begin
            beat_data[i] = {$urandom, $urandom};
        end
        n      = 0;
        trig_a = -1; trig_b = -1; trig_c = -1;
        valid_rand = 1'b0; ready_rand = 1'b0;
        model_reset();

        // Reset state
        repeat (2) @(negedge clk);
        check_eq("rst_tvalid", m_tvalid, 1'b0);
        check_eq("rst_tlast", m_tlast, 1'b0);
        check_eq("rst_tdata", m_tdata, 32'h0);
        check_eq("rst_busy", busy, 1'b1);
        check_eq("rst_tready", s_tready, 1'b0);
        check_eq("tstrb", m_tstrb, 4'hF);
        rst = 1'b0;

        // Early pulse in PREFILL ignored, real trigger at beat 10, sign-extension extremes.
        seen_q.delete();
        beat_data[n + 6] = {16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000};
        trig_a = n + 2;
        trig_b = n + 10;
        repeat (200) step();
        end_of_frame_checks("A");
        if (seen_q.size() >= HDR + 2) begin
            check_eq("sext_neg", seen_q[HDR], 32'hFFFF8000);
            check_eq("sext_pos", seen_q[HDR + 1], 32'h00007FFF);
        end
`ifdef TRIGGER_CAPTURE_HEADER_EN
        if (seen_q.size() != 0) check_eq("hdr_frame0", seen_q[0], 32'h00000004);
`endif

        // Random output backpressure and input gaps, extra pulse during capture.
        seen_q.delete();
        valid_rand = 1'b1;
        ready_rand = 1'b1;
        trig_a = -1;
        trig_b = n + PW + $urandom_range(0, 8);
        trig_c = trig_b + 3;
        repeat (500) step();
        end_of_frame_checks("B");
`ifdef TRIGGER_CAPTURE_HEADER_EN
        if (seen_q.size() != 0) check_eq("hdr_frame1", seen_q[0], 32'h00010004);
`endif

        // Reset in the middle of a dump.
        seen_q.delete();
        valid_rand = 1'b0;
        ready_rand = 1'b0;
        trig_b = n + PW + 1;
        trig_c = -1;
        cyc = 0;
        while (seen_q.size() < 20 && cyc < 300) begin
            step();
            cyc++;
        end
        check_eq("reach_20", seen_q.size() >= 20, 1'b1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        idle_inputs();
        #1;
        check_eq("mid_rst_tvalid", m_tvalid, 1'b0);
        check_eq("mid_rst_tlast", m_tlast, 1'b0);
        check_eq("mid_rst_tdata", m_tdata, 32'h0);
        check_eq("mid_rst_busy", busy, 1'b1);
        check_eq("mid_rst_tready", s_tready, 1'b0);
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // A full frame after the interrupted one.
        seen_q.delete();
        ready_rand = 1'b1;
        trig_b = n + PW + 3;
        repeat (300) step();
        end_of_frame_checks("D");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_trigger_capture_buffer
